// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_pkg
// Brief    : Opcode/funct constants and instruction field positions for ID.
// Revision : 1.0
// ============================================================================
package id_stage_pipe_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FUNCT_NOP  = 6'h00;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam int ZERO_REG_ADDR = 0;

    typedef enum logic [1:0] {
        INST_R   = 2'd0,
        INST_I   = 2'd1,
        INST_LUI = 2'd2,
        INST_NOP = 2'd3
    } inst_class_t;

endpackage
`default_nettype wire

// File: rtl/id_operand_mux.sv
`default_nettype none
// ============================================================================
// Module   : id_operand_mux
// Brief    : Resolves one read operand against prioritised forwarding sources.
// Revision : 1.0
// ============================================================================
module id_operand_mux
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_FWD        = 2
) (
    input  logic                             read_en,
    input  logic [REG_ADDR_WIDTH-1:0]        read_addr,
    input  logic [DATA_WIDTH-1:0]            reg_data,
    input  logic [NUM_FWD-1:0]               fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data,
    output logic [DATA_WIDTH-1:0]            operand
);

    always_comb begin
        operand = reg_data;
        // Walk from oldest to youngest so the lowest matching index wins.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == read_addr)) begin
                operand = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (!read_en || (read_addr == REG_ADDR_WIDTH'(ZERO_REG_ADDR))) begin
            operand = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Brief    : Registered decode stage with handshakes, forwarding, load-use stall.
// Revision : 1.0
// ============================================================================
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_FWD        = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ADDR_WIDTH-1:0]             in_addr,
    input  logic [31:0]                       in_inst,
    output logic                              reg_read_en_1,
    output logic                              reg_read_en_2,
    output logic [REG_ADDR_WIDTH-1:0]         reg_addr_1,
    output logic [REG_ADDR_WIDTH-1:0]         reg_addr_2,
    input  logic [DATA_WIDTH-1:0]             reg_data_1,
    input  logic [DATA_WIDTH-1:0]             reg_data_2,
    input  logic [NUM_FWD-1:0]                fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_WIDTH-1:0]     fwd_data,
    input  logic                              ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0]         ex_write_addr,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ADDR_WIDTH-1:0]             out_addr,
    output logic [5:0]                        out_funct,
    output logic [DATA_WIDTH-1:0]             out_operand_1,
    output logic [DATA_WIDTH-1:0]             out_operand_2,
    output logic [4:0]                        out_shamt,
    output logic                              out_write_reg_en,
    output logic [REG_ADDR_WIDTH-1:0]         out_write_reg_addr
);

    logic [5:0]                w_opcode;
    logic [15:0]               w_imm;
    logic [REG_ADDR_WIDTH-1:0] w_rs;
    logic [REG_ADDR_WIDTH-1:0] w_rt;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    inst_class_t               w_class;
    logic                      w_rd_en_1;
    logic                      w_rd_en_2;
    logic [5:0]                w_funct;
    logic [4:0]                w_shamt;
    logic [REG_ADDR_WIDTH-1:0] w_dest;
    logic                      w_write_en;
    logic                      w_use_imm;
    logic [DATA_WIDTH-1:0]     w_imm_val;
    logic [DATA_WIDTH-1:0]     w_res_1;
    logic [DATA_WIDTH-1:0]     w_res_2;
    logic                      w_hazard;

    logic                      r_valid;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [5:0]                r_funct;
    logic [DATA_WIDTH-1:0]     r_op_1;
    logic [DATA_WIDTH-1:0]     r_op_2;
    logic [4:0]                r_shamt;
    logic                      r_write_en;
    logic [REG_ADDR_WIDTH-1:0] r_write_addr;

    assign w_opcode = in_inst[OPCODE_MSB:OPCODE_LSB];
    assign w_imm    = in_inst[IMM_MSB:IMM_LSB];
    assign w_rs     = REG_ADDR_WIDTH'(in_inst[RS_MSB:RS_LSB]);
    assign w_rt     = REG_ADDR_WIDTH'(in_inst[RT_MSB:RT_LSB]);
    assign w_rd     = REG_ADDR_WIDTH'(in_inst[RD_MSB:RD_LSB]);

    always_comb begin
        w_class   = INST_NOP;
        w_funct   = FUNCT_NOP;
        w_imm_val = '0;
        case (w_opcode)
            OP_SPECIAL: begin
                w_class = INST_R;
                w_funct = in_inst[FUNCT_MSB:FUNCT_LSB];
            end
            OP_ORI: begin
                w_class   = INST_I;
                w_funct   = FUNCT_OR;
                w_imm_val = DATA_WIDTH'(w_imm);
            end
            OP_ANDI: begin
                w_class   = INST_I;
                w_funct   = FUNCT_AND;
                w_imm_val = DATA_WIDTH'(w_imm);
            end
            OP_XORI: begin
                w_class   = INST_I;
                w_funct   = FUNCT_XOR;
                w_imm_val = DATA_WIDTH'(w_imm);
            end
            OP_ADDIU: begin
                w_class   = INST_I;
                w_funct   = FUNCT_ADDU;
                w_imm_val = {{(DATA_WIDTH-16){w_imm[15]}}, w_imm};
            end
            OP_LUI: begin
                w_class   = INST_LUI;
                w_funct   = FUNCT_OR;
                w_imm_val = DATA_WIDTH'({w_imm, 16'h0000});
            end
            default: ;
        endcase
    end

    // LUI reads nothing, so its operand_1 resolves to zero through the mux.
    always_comb begin
        w_rd_en_1  = 1'b0;
        w_rd_en_2  = 1'b0;
        w_shamt    = 5'd0;
        w_dest     = '0;
        w_write_en = 1'b0;
        w_use_imm  = 1'b0;
        case (w_class)
            INST_R: begin
                w_rd_en_1  = 1'b1;
                w_rd_en_2  = 1'b1;
                w_shamt    = in_inst[SHAMT_MSB:SHAMT_LSB];
                w_dest     = w_rd;
                w_write_en = 1'b1;
            end
            INST_I: begin
                w_rd_en_1  = 1'b1;
                w_dest     = w_rt;
                w_write_en = 1'b1;
                w_use_imm  = 1'b1;
            end
            INST_LUI: begin
                w_dest     = w_rt;
                w_write_en = 1'b1;
                w_use_imm  = 1'b1;
            end
            default: ;
        endcase
        if (w_dest == REG_ADDR_WIDTH'(ZERO_REG_ADDR)) begin
            w_write_en = 1'b0;
        end
    end

    id_operand_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_FWD        (NUM_FWD)
    ) u_mux_1 (
        .read_en   (w_rd_en_1),
        .read_addr (w_rs),
        .reg_data  (reg_data_1),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .operand   (w_res_1)
    );

    id_operand_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_FWD        (NUM_FWD)
    ) u_mux_2 (
        .read_en   (w_rd_en_2),
        .read_addr (w_rt),
        .reg_data  (reg_data_2),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .operand   (w_res_2)
    );

    assign w_hazard = ex_is_load
                   && (ex_write_addr != REG_ADDR_WIDTH'(ZERO_REG_ADDR))
                   && ((w_rd_en_1 && (ex_write_addr == w_rs))
                    || (w_rd_en_2 && (ex_write_addr == w_rt)));

    assign in_ready      = !flush && !w_hazard && (!r_valid || out_ready);
    assign reg_read_en_1 = w_rd_en_1;
    assign reg_read_en_2 = w_rd_en_2;
    assign reg_addr_1    = w_rs;
    assign reg_addr_2    = w_rt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_funct      <= FUNCT_NOP;
            r_op_1       <= '0;
            r_op_2       <= '0;
            r_shamt      <= 5'd0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_valid      <= 1'b1;
            r_addr       <= in_addr;
            r_funct      <= w_funct;
            r_op_1       <= w_res_1;
            r_op_2       <= w_use_imm ? w_imm_val : w_res_2;
            r_shamt      <= w_shamt;
            r_write_en   <= w_write_en;
            r_write_addr <= w_dest;
        end else if (out_ready && (w_hazard || !in_valid)) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid          = r_valid;
    assign out_addr           = r_addr;
    assign out_funct          = r_funct;
    assign out_operand_1      = r_op_1;
    assign out_operand_2      = r_op_2;
    assign out_shamt          = r_shamt;
    assign out_write_reg_en   = r_write_en;
    assign out_write_reg_addr = r_write_addr;

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered instruction-decode stage with an ID/EX output register, valid/ready handshakes on both sides, N-source operand forwarding and load-use stall.
- Decodes R-type and I-type ALU instructions, reads the register file combinationally, resolves operands against forwarding sources and issues one decoded op per cycle to EX.
- Sits between the IF/ID register and EX.
- Generalises the combinational decoder with parametrised width, forwarding fan-in, backpressure, flush and hazard bubbles.

Parameters:
- DATA_WIDTH, 32, operand/register data width
- ADDR_WIDTH, 32, instruction address width
- REG_ADDR_WIDTH, 5, register index width
- NUM_FWD, 2, number of forwarding sources; index 0 has highest priority (youngest)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard output register contents and block input this cycle
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  this stage accepts the instruction at this edge
- in_addr  in  ADDR_WIDTH  instruction address
- in_inst  in  32  instruction word
- reg_read_en_1 / reg_read_en_2  out  1  register-file read enables
- reg_addr_1 / reg_addr_2  out  REG_ADDR_WIDTH  read indices (rs / rt)
- reg_data_1 / reg_data_2  in  DATA_WIDTH  same-cycle read data
- fwd_valid  in  NUM_FWD  forwarding source i carries a pending write
- fwd_addr  in  NUM_FWD*REG_ADDR_WIDTH  destination of source i (slice i)
- fwd_data  in  NUM_FWD*DATA_WIDTH  result of source i
- ex_is_load  in  1  instruction now in EX is a load (data not forwardable)
- ex_write_addr  in  REG_ADDR_WIDTH  destination of that load
- out_valid  out  1  decoded op valid
- out_ready  in  1  EX accepts op
- out_addr  out  ADDR_WIDTH  address of issued op
- out_funct  out  6  ALU function code
- out_operand_1 / out_operand_2  out  DATA_WIDTH  resolved operands
- out_shamt  out  5  shift amount
- out_write_reg_en  out  1  writeback enable
- out_write_reg_addr  out  REG_ADDR_WIDTH  writeback index

Behaviour:
- Reset (async): out_valid=0; all registered outputs 0 (funct NOP=6'h00, write disabled). Release takes effect at the next clk edge.
- Decode (combinational from in_inst):
  - R-type (op 0): rs/rt read, funct=inst[5:0], shamt=inst[10:6], dest rd.
  - I-type: rs read only, dest rt, shamt 0.
    - ORI -> funct 6'h25, zero-extended imm.
    - ANDI -> 6'h24, zero-extended imm.
    - XORI -> 6'h26, zero-extended imm.
    - ADDIU -> 6'h21, sign-extended imm.
    - LUI -> 6'h25, operand_1=0, operand_2={imm,16'b0}, no reads.
  - Unknown opcode -> NOP: read enables 0, operands 0, write disabled.
  - Immediates extended to DATA_WIDTH.
- Operand resolution, per read port:
  - Index 0 or read disabled -> 0.
  - Else the lowest i with fwd_valid[i] and matching fwd_addr -> fwd_data[i].
  - Else reg_data.
  - Destination 0 always forces write_reg_en=0.
- hazard = ex_is_load AND ex_write_addr != 0 AND matches an enabled source index.
- in_ready = !flush AND !hazard AND (!out_valid OR out_ready).
- Edge behaviour (priority flush > load > drain > hold):
  - flush: out_valid <= 0.
  - in_valid && in_ready: load decoded op, out_valid <= 1.
  - out_ready && (hazard or !in_valid): out_valid <= 0 (bubble).
  - otherwise hold all outputs stable (no re-sampling of forwarding while stalled).
- Latency 1 cycle: accepted at edge N, visible after edge N. Throughput 1/cycle with out_ready=1.
- Hazard lasts exactly while inputs assert it; no internal counting.
- Reset mid-stall discards the held op.

Decomposition:
- Shared package/define file:
  - opcode constants: OP_SPECIAL, OP_ORI, OP_ANDI, OP_XORI, OP_ADDIU, OP_LUI.
  - FUNCT_* constants and FUNCT_NOP.
  - instruction field positions.
  - ZERO_REG_ADDR.
- Sub-module id_operand_mux (parametrised DATA_WIDTH, REG_ADDR_WIDTH, NUM_FWD), instantiated twice for ports 1 and 2.
- Decode logic and the output register live in the top module.

Test Plan:
- Reset during out_valid=1 -> out_valid 0 and all outputs 0 immediately, before any clk edge.
- ORI r2,r1,0x00F0 with reg_data_1=0x12340000 -> next cycle funct 6'h25, operands 0x12340000/0x000000F0, write r2.
- ADDU r3,r1,r2 with fwd0={r1,0xAAAA0000} and fwd1={r1,0x11111111} -> operand_1 0xAAAA0000 (source 0 wins); r0 source yields 0 despite a matching fwd.
- ex_is_load=1, ex_write_addr=r1, ADDIU r4,r1,-1 presented -> in_ready 0 and bubble out; hazard drops -> issued with operand_2 0xFFFFFFFF.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready 0; release -> back-to-back ops issued with no loss or duplication.
- flush with in_valid=1 -> in_ready 0, out_valid 0 next cycle, instruction issued only after re-presentation.
